dpa_mul_word_sequencer: RTL and testbench

Bit-serial controller that computes the share-wise masked AND of two WIDTH-bit masked words by sequencing one `DPA_1bit_mul_v` gate over all bit positions. It accepts masked operands over a valid/ready handshake and pulls fresh randomness from a random-source handshake for every bit it issues. It then collects the gate's registered output shares into a masked result word and presents that word over a valid/ready handshake. It sits between the ALU function-array front end and the shared masked multiplier resource.

---
 rtl/dpa_pkg.sv | 32 +++
 rtl/DPA_1bit_mul_v.sv | 45 ++++
 rtl/dpa_mul_word_sequencer.sv | 139 +++++++++++++
 tb/tb_dpa_mul_word_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : dpa_pkg                                                       |
// | Description : Shared types and helpers for the masked multiplier sequencer. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package dpa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int c_default_shares = 3;
    localparam int c_default_width  = 8;

    typedef logic [c_default_width-1:0]                      dpa_word_t;
    typedef dpa_word_t [c_default_shares-1:0]                dpa_share_word_t;

    function automatic int rand_bits(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Position of the random bit shared by share pair (i, j), i < j, in the flat rnd vector.
    function automatic int pair_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/DPA_1bit_mul_v.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : DPA_1bit_mul_v                                                |
// | Description : One-bit masked AND gate with a registered output per share.   |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module DPA_1bit_mul_v
    import dpa_pkg::*;
#(
    parameter int NUMBER_OF_SHARES = 3
) (
    input  logic                                    clock,
    input  logic [NUMBER_OF_SHARES-1:0]             x,
    input  logic [NUMBER_OF_SHARES-1:0]             y,
    input  logic [rand_bits(NUMBER_OF_SHARES)-1:0]  r,
    output logic [NUMBER_OF_SHARES-1:0]             q
);

    logic [NUMBER_OF_SHARES-1:0] w_q_next;
    logic [NUMBER_OF_SHARES-1:0] r_q;

    // Each cross product is refreshed by the random bit of its share pair,
    // so every random bit lands in exactly two output shares.
    for (genvar i = 0; i < NUMBER_OF_SHARES; i++) begin : g_share
        logic [NUMBER_OF_SHARES-1:0] w_term;
        for (genvar j = 0; j < NUMBER_OF_SHARES; j++) begin : g_term
            if (j == i) begin : g_inner
                assign w_term[j] = x[i] & y[i];
            end else if (j > i) begin : g_upper
                assign w_term[j] = (x[i] & y[j]) ^ r[pair_index(i, j, NUMBER_OF_SHARES)];
            end else begin : g_lower
                assign w_term[j] = (x[i] & y[j]) ^ r[pair_index(j, i, NUMBER_OF_SHARES)];
            end
        end
        assign w_q_next[i] = ^w_term;
    end

    always_ff @(posedge clock) begin
        r_q <= w_q_next;
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dpa_mul_word_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : dpa_mul_word_sequencer                                        |
// | Description : Bit-serial masked AND of two shared words over one 1-bit gate.|
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module dpa_mul_word_sequencer
    import dpa_pkg::*;
#(
    parameter int NUMBER_OF_SHARES = 3,
    parameter int WIDTH            = 8
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]      x,
    input  logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]      y,
    input  logic                                        rnd_valid,
    output logic                                        rnd_ready,
    input  logic [rand_bits(NUMBER_OF_SHARES)-1:0]      rnd,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]      q
);

    localparam int R_BITS = rand_bits(NUMBER_OF_SHARES);
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);

    seq_state_t                                 r_state;
    seq_state_t                                 w_state_next;
    logic [CNT_W-1:0]                           r_bit_idx;
    logic [CNT_W-1:0]                           r_inflight_idx;
    logic                                       r_inflight;
    logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]     r_x;
    logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]     r_y;
    logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]     r_res;
    logic [NUMBER_OF_SHARES-1:0][WIDTH-1:0]     w_res_next;
    logic                                       w_accept;
    logic                                       w_issue;
    logic                                       w_release;
    logic [NUMBER_OF_SHARES-1:0]                w_gate_x;
    logic [NUMBER_OF_SHARES-1:0]                w_gate_y;
    logic [NUMBER_OF_SHARES-1:0]                w_gate_q;
    logic [R_BITS-1:0]                          w_gate_r;
    logic [WIDTH-1:0]                           w_cap_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)                              w_state_next = RUN;
            RUN:     if (rnd_valid && (r_bit_idx == c_last_idx)) w_state_next = DRAIN;
            DRAIN:                                              w_state_next = DONE;
            DONE:    if (out_ready)                             w_state_next = IDLE;
            default:                                            w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        rnd_ready = (r_state == RUN);
        out_valid = (r_state == DONE);
        w_accept  = in_ready  & in_valid;
        w_issue   = rnd_ready & rnd_valid;
        w_release = out_valid & out_ready;
    end

    // Gate inputs are forced to zero on non-issue cycles so no stale operand bit reaches the gate.
    assign w_gate_r   = w_issue ? rnd : '0;
    assign w_cap_mask = r_inflight ? (WIDTH'(1) << r_inflight_idx) : '0;

    for (genvar i = 0; i < NUMBER_OF_SHARES; i++) begin : g_lane
        logic [WIDTH-1:0] w_x_shift;
        logic [WIDTH-1:0] w_y_shift;
        assign w_x_shift     = r_x[i] >> r_bit_idx;
        assign w_y_shift     = r_y[i] >> r_bit_idx;
        assign w_gate_x[i]   = w_issue & w_x_shift[0];
        assign w_gate_y[i]   = w_issue & w_y_shift[0];
        assign w_res_next[i] = (r_res[i] & ~w_cap_mask) | ({WIDTH{w_gate_q[i]}} & w_cap_mask);
    end

    DPA_1bit_mul_v #(
        .NUMBER_OF_SHARES (NUMBER_OF_SHARES)
    ) u_gate (
        .clock (clock),
        .x     (w_gate_x),
        .y     (w_gate_y),
        .r     (w_gate_r),
        .q     (w_gate_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x            <= '0;
            r_y            <= '0;
            r_bit_idx      <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_x       <= x;
                r_y       <= y;
                r_bit_idx <= '0;
            end else if (w_release) begin
                r_x <= '0;
                r_y <= '0;
            end
            if (w_issue) begin
                r_bit_idx      <= r_bit_idx + CNT_W'(1);
                r_inflight_idx <= r_bit_idx;
            end
        end
    end

    // The gate output of an issue arrives one cycle later, tagged by r_inflight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res <= '0;
        end else if (w_release) begin
            r_res <= '0;
        end else begin
            r_res <= w_res_next;
        end
    end

    assign q = r_res;

endmodule
`default_nettype wire

// File: tb/tb_dpa_mul_word_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_dpa_mul_word_sequencer                                     |
// | Description : Scoreboard bench for the masked word multiplier sequencer.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_dpa_mul_word_sequencer;

    localparam int N = 3;
    localparam int W = 8;
    localparam int BASE_LAT = W + 2;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    logic                 clock;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0][W-1:0]  x;
    logic [N-1:0][W-1:0]  y;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [2:0]           rnd;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0][W-1:0]  q;

    dpa_mul_word_sequencer #(
        .NUMBER_OF_SHARES (N),
        .WIDTH            (W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    int stall_left = 0;
    int bp_left = 0;
    int rnd_mode = 2;
    int job_hs = 0;
    int done_count = 0;
    bit expect_b2b = 0;
    int accept_cyc = 0;
    int last_out_cyc = -100;
    logic [N-1:0][W-1:0] last_q = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0][W-1:0] split(input logic [W-1:0] v);
        logic [N-1:0][W-1:0] s;
        s[0] = 8'($urandom);
        s[1] = 8'($urandom);
        s[2] = v ^ s[0] ^ s[1];
        return s;
    endfunction

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Random source: new word after every consumed one, optional stall before bit 4.
    initial begin
        bit need;
        rnd = '0;
        rnd_valid = 1'b0;
        forever begin
            @(negedge clock);
            need = rnd_valid && rnd_ready && reset_n;
            @(posedge clock);
            #1;
            if (rnd_mode == 0)      rnd = 3'b000;
            else if (rnd_mode == 1) rnd = 3'b111;
            else if (need)          rnd = 3'($urandom);
            rnd_valid = !(stall_left > 0 && job_hs == 4 && rnd_ready);
            if (!rnd_valid) stall_left--;
        end
    end

    // Consumer: holds off out_ready for bp_left cycles of out_valid.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (out_valid && bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: timing, hold, zeroization and scoreboard comparison.
    initial begin
        bit prev_ov = 0;
        bit zero_next = 0;
        logic [N-1:0][W-1:0] q_hold = '0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_ov = 0;
                zero_next = 0;
                job_hs = 0;
            end else begin
                if (zero_next) begin
                    chk("idle_in_ready", 64'(in_ready), 64'(1));
                    chk("idle_q_zero", 64'(q), 64'(0));
                    zero_next = 0;
                end
                if (in_valid && in_ready) begin
                    accept_cyc = cyc;
                    job_hs = 0;
                    if (expect_b2b) begin
                        chk("b2b_accept_cycle", 64'(cyc), 64'(last_out_cyc + 1));
                        expect_b2b = 0;
                    end
                end
                if (rnd_valid && rnd_ready) job_hs++;
                if (out_valid) begin
                    if (!prev_ov) begin
                        q_hold = q;
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output actual=out_valid required=no_output (cycle %0d)", cyc);
                        end else begin
                            chk("latency", 64'(cyc - accept_cyc), 64'(sb[0].lat));
                        end
                    end else begin
                        chk("hold_q", 64'(q), 64'(q_hold));
                    end
                    if (!out_ready) begin
                        chk("bp_in_ready", 64'(in_ready), 64'(0));
                        chk("bp_rnd_ready", 64'(rnd_ready), 64'(0));
                    end else if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("result", 64'(q[0] ^ q[1] ^ q[2]), 64'(e.res));
                        chk("rnd_handshakes", 64'(job_hs), 64'(W));
                        last_q = q;
                        last_out_cyc = cyc;
                        done_count++;
                        zero_next = 1;
                    end
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic send(input logic [N-1:0][W-1:0] xs, input logic [N-1:0][W-1:0] ys,
                        input int extra_lat);
        bit hs;
        bit ok = 0;
        exp_t e;
        x = xs;
        y = ys;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            hs = in_ready;
            @(posedge clock);
            #1;
            if (hs) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (ok) begin
            e.res = (xs[0] ^ xs[1] ^ xs[2]) & (ys[0] ^ ys[1] ^ ys[2]);
            e.lat = BASE_LAT + extra_lat;
            sb.push_back(e);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300; i++) begin
            @(posedge clock);
            if (done_count >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=%0d required=%0d", done_count, target);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0][W-1:0] xs;
        logic [N-1:0][W-1:0] ys;
        logic [N-1:0][W-1:0] qa;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int st;

        reset_n = 1'b0;
        in_valid = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_rnd_ready", 64'(rnd_ready), 64'(0));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_q", 64'(q), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        send(split(8'hA5), split(8'h3C), 0);
        wait_done(1);

        stall_left = 3;
        send(split(8'hA5), split(8'h3C), 3);
        wait_done(2);

        bp_left = 5;
        send(split(8'hA5), split(8'h3C), 0);
        wait_done(3);

        // Same operand values, all-zero then all-one randomness, x re-masked by 0xFF.
        rnd_mode = 0;
        xs = split(8'hA5);
        ys = split(8'h3C);
        send(xs, ys, 0);
        wait_done(4);
        qa = last_q;
        rnd_mode = 1;
        xs[0] = xs[0] ^ 8'hFF;
        xs[1] = xs[1] ^ 8'hFF;
        send(xs, ys, 0);
        wait_done(5);
        checks++;
        if (last_q === qa) begin
            errors++;
            $display("FAIL mask_shares_differ actual=%0h required=not_%0h", last_q, qa);
        end
        rnd_mode = 2;

        send(split(8'hA5), split(8'h3C), 0);
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'(1));
        chk("midreset_q", 64'(q), 64'(0));
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        chk("midreset_rnd_ready", 64'(rnd_ready), 64'(0));
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send(split(8'hFF), split(8'h0F), 0);
        wait_done(6);
        chk("abort_no_output", 64'(done_count), 64'(6));

        send(split(8'h5A), split(8'hF0), 0);
        expect_b2b = 1;
        send(split(8'hC3), split(8'h99), 0);
        wait_done(8);
        chk("b2b_checked", 64'(expect_b2b), 64'(0));

        for (int k = 0; k < 6; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            bp_left = $urandom_range(0, 3);
            st = $urandom_range(0, 2);
            stall_left = st;
            send(split(a), split(b), st);
            wait_done(9 + k);
        end

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
